sad_search_ctrl: RTL
====================

Name: sad_search_ctrl

Overview:
- Sequencer for the combinational SAD datapath in motion-estimation block matching.
- Walks NCAND candidate blocks of ROWS rows each. Each row is one INPUTS-pixel SAD evaluation.
- Drives candidate/row read addresses and accumulates the per-row SAD returned by the datapath.
- Tracks the minimum block SAD and its candidate index, and reports the winner with a done pulse.

Parameters:
WIDTH, 8, pixel bit width (matches SAD datapath)
INPUTS, 4, pixels per row evaluation (matches SAD datapath)
ROWS, 4, rows per block, >=1
NCAND, 16, candidates per search, >=1
SAD_W, WIDTH+$clog2(INPUTS), width of per-row SAD from datapath
ACC_W, SAD_W+$clog2(ROWS)+1, block accumulator / best_sad width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin search; sampled in IDLE only
abort  input  1  cancel search; returns to IDLE
rd_en  output  1  address valid; pixel memories read with 1-cycle latency
cand_idx  output  $clog2(NCAND) (min 1)  candidate address
row_idx  output  $clog2(ROWS) (min 1)  row address
sad_in  input  SAD_W  row SAD from datapath; valid the cycle after rd_en
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse, search complete
best_sad  output  ACC_W  minimum block SAD
best_idx  output  $clog2(NCAND) (min 1)  candidate giving best_sad
best_valid  output  1  best_* hold a completed search result

Behaviour:
- Reset (async, rst_n=0): state IDLE; rd_en, busy and done =0; cand_idx, row_idx =0; best_sad=0, best_idx=0, best_valid=0; accumulator =0; internal valid pipe =0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 → RUN.
  - On this transition: clear cand_idx, row_idx and accumulator; best_sad=all ones; best_idx=0; best_valid=0.
- RUN:
  - rd_en=1 every cycle.
  - row_idx increments each cycle, wrapping at ROWS-1. cand_idx increments on that wrap.
  - Issuing cand=NCAND-1, row=ROWS-1 → DRAIN next cycle.
  - N = NCAND*ROWS issue cycles.
- Datapath timing:
  - vld = rd_en delayed 1 cycle, with row/cand tags delayed alongside.
  - When vld and tag row≠ROWS-1: acc ← acc + sad_in.
  - When vld and tag row=ROWS-1: total = acc + sad_in; acc ← 0.
    - If total < best_sad (strict), best_sad ← total and best_idx ← tag cand.
    - Ties keep the lower index.
  - All additions are zero-extended to ACC_W. There is no overflow: max total = ROWS*(2^WIDTH-1)*INPUTS.
- DRAIN: rd_en=0, busy=1. The final row result is consumed this cycle → DONE.
- DONE: done=1 for this cycle only; best_valid ← 1; busy=0 → IDLE.
- Latency: start sampled at edge 0 → rd_en cycles 1..N, DRAIN at N+1, done at cycle N+2.
  - Defaults: done in cycle 66 after start.
- best_* and best_valid hold until the next accepted start or reset.
- start while not IDLE: ignored.
- start in DONE cycle: ignored. Restart requires IDLE.
- abort:
  - Priority over all transitions in RUN/DRAIN/DONE.
  - Next state IDLE; rd_en, busy and done drop the next cycle; vld pipe cleared.
  - best_valid stays 0; best_sad/best_idx hold partial values and are not meaningful.
  - abort in IDLE: no effect.
- abort and start both high in IDLE: abort wins, stay IDLE.
- Reset mid-operation: immediate return to reset values; no done pulse.
- NCAND=1 or ROWS=1 supported. Index widths are forced to a minimum of 1 bit.

Test Plan:
- Defaults, sad_in=10 constant → done at cycle 66, best_sad=40, best_idx=0, best_valid=1; rd_en high exactly 64 cycles.
- sad_in=1 for all rows of candidate 5, 10 elsewhere → best_sad=4, best_idx=5.
- Candidates 3 and 9 both total 8, others 40 → best_idx=3 (tie keeps lower).
- sad_in=1020 all rows (max) → best_sad=4080, no wrap.
- abort at cycle 20 → rd_en/busy low at cycle 21, no done, best_valid=0; new start then completes normally. start pulses during RUN → ignored, single done.
- rst_n low at cycle 30 → all outputs at reset values immediately. ROWS=1, NCAND=1 with sad_in=7 → done at cycle 3, best_sad=7, best_idx=0.

Source files
------------

// File: rtl/sad_search_if.sv
// ---------------------------------------------------------------------------
// sad_search_if : controller <-> SAD datapath / host signal bundle.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sad_search_if #(
  parameter int WIDTH  = 8,
  parameter int INPUTS = 4,
  parameter int ROWS   = 4,
  parameter int NCAND  = 16
);
  localparam int SAD_W = WIDTH + $clog2(INPUTS);
  localparam int ACC_W = SAD_W + $clog2(ROWS) + 1;
  localparam int CW    = (NCAND > 1) ? $clog2(NCAND) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic             start;
  logic             abort;
  logic             rd_en;
  logic [CW-1:0]    cand_idx;
  logic [RW-1:0]    row_idx;
  logic [SAD_W-1:0] sad_in;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] best_sad;
  logic [CW-1:0]    best_idx;
  logic             best_valid;

  modport master (
    input  start, abort, sad_in,
    output rd_en, cand_idx, row_idx, busy, done, best_sad, best_idx, best_valid
  );

  modport slave (
    output start, abort, sad_in,
    input  rd_en, cand_idx, row_idx, busy, done, best_sad, best_idx, best_valid
  );
endinterface

`default_nettype wire

// File: rtl/sad_search_ctrl.sv
// ---------------------------------------------------------------------------
// sad_search_ctrl : walks candidates/rows, accumulates row SADs, keeps min.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sad_search_ctrl #(
  parameter int WIDTH  = 8,
  parameter int INPUTS = 4,
  parameter int ROWS   = 4,
  parameter int NCAND  = 16
) (
  input wire           clk,
  input wire           rst_n,
  sad_search_if.master bus
);
  localparam int SAD_W = WIDTH + $clog2(INPUTS);
  localparam int ACC_W = SAD_W + $clog2(ROWS) + 1;
  localparam int CW    = (NCAND > 1) ? $clog2(NCAND) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [CW-1:0] c_CAND_LAST = CW'(NCAND - 1);
  localparam logic [RW-1:0] c_ROW_LAST  = RW'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_rd_en;
  logic             r_busy;
  logic             r_done;
  logic             r_best_valid;
  logic             r_vld;
  logic [CW-1:0]    r_cand;
  logic [CW-1:0]    r_tag_cand;
  logic [CW-1:0]    r_best_idx;
  logic [RW-1:0]    r_row;
  logic [RW-1:0]    r_tag_row;
  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_best_sad;

  logic [ACC_W-1:0] w_sad_ext;
  logic [ACC_W-1:0] w_total;
  logic             w_accept;
  logic             w_abort;
  logic             w_row_wrap;
  logic             w_last_issue;
  logic             w_tag_last;

  assign w_sad_ext    = {{(ACC_W-SAD_W){1'b0}}, bus.sad_in};
  assign w_total      = r_acc + w_sad_ext;
  assign w_accept     = (r_state == S_IDLE) && bus.start && !bus.abort;
  assign w_abort      = (r_state != S_IDLE) && bus.abort;
  assign w_row_wrap   = (r_row == c_ROW_LAST);
  assign w_last_issue = w_row_wrap && (r_cand == c_CAND_LAST);
  assign w_tag_last   = (r_tag_row == c_ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rd_en      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_best_valid <= 1'b0;
      r_vld        <= 1'b0;
      r_cand       <= '0;
      r_row        <= '0;
      r_tag_cand   <= '0;
      r_tag_row    <= '0;
    end else if (w_abort) begin
      r_state <= S_IDLE;
      r_rd_en <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_vld   <= 1'b0;
    end else begin
      // Tags travel with the read so the returning SAD knows its row/candidate.
      r_vld      <= r_rd_en;
      r_tag_cand <= r_cand;
      r_tag_row  <= r_row;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state      <= S_RUN;
            r_rd_en      <= 1'b1;
            r_busy       <= 1'b1;
            r_cand       <= '0;
            r_row        <= '0;
            r_best_valid <= 1'b0;
          end
        end
        S_RUN: begin
          r_row <= w_row_wrap ? '0 : r_row + 1'b1;
          if (w_row_wrap) begin
            r_cand <= (r_cand == c_CAND_LAST) ? '0 : r_cand + 1'b1;
          end
          if (w_last_issue) begin
            r_state <= S_DRAIN;
            r_rd_en <= 1'b0;
          end
        end
        S_DRAIN: begin
          r_state      <= S_DONE;
          r_busy       <= 1'b0;
          r_done       <= 1'b1;
          r_best_valid <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc      <= '0;
      r_best_sad <= '0;
      r_best_idx <= '0;
    end else if (w_accept) begin
      r_acc      <= '0;
      r_best_sad <= '1;
      r_best_idx <= '0;
    end else if (w_abort) begin
      r_acc <= '0;
    end else if (r_vld) begin
      if (w_tag_last) begin
        r_acc <= '0;
        // Strict compare: on a tie the earlier (lower) candidate is kept.
        if (w_total < r_best_sad) begin
          r_best_sad <= w_total;
          r_best_idx <= r_tag_cand;
        end
      end else begin
        r_acc <= w_total;
      end
    end
  end

  assign bus.rd_en      = r_rd_en;
  assign bus.cand_idx   = r_cand;
  assign bus.row_idx    = r_row;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.best_sad   = r_best_sad;
  assign bus.best_idx   = r_best_idx;
  assign bus.best_valid = r_best_valid;
endmodule

`default_nettype wire
